// File: rtl/axil_iic_pkg.sv
// Shared types and constants for the AXI4-Lite initiator that drives the axi_iic_0 register map.
package axil_iic_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [8:0] REG_CR      = 9'h100;
  localparam logic [8:0] REG_SR      = 9'h104;
  localparam logic [8:0] REG_TX_FIFO = 9'h108;
  localparam logic [8:0] REG_RX_FIFO = 9'h10C;
  localparam logic [8:0] REG_GPO     = 9'h124;

  // States in which the block is waiting on the slave and the watchdog runs.
  function automatic logic is_wait_state(input state_e st);
    logic busy;
    case (st)
      ST_WR, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA: busy = 1'b1;
      default:                                    busy = 1'b0;
    endcase
    return busy;
  endfunction

endpackage

// File: rtl/axil_iic_wdog.sv
// Saturating stall counter with a sticky hang flag; set has priority over hang_clr.
module axil_iic_wdog #(
  parameter int WDOG_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  input  logic hang_clr,
  output logic hang
);

  localparam logic [15:0] LAST = 16'(WDOG_CYCLES - 1);

  logic [15:0] count_r;
  logic        at_last_s;
  logic        set_s;

  assign at_last_s = (count_r == LAST);
  assign set_s     = run & ~clr & at_last_s;

  // Count cycles spent in one waiting state and latch hang once the limit is hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 16'd0;
      hang    <= 1'b0;
    end else begin
      if (clr) begin
        count_r <= 16'd0;
      end else if (run & ~at_last_s) begin
        count_r <= count_r + 16'd1;
      end else begin
        count_r <= count_r;
      end

      if (set_s) begin
        hang <= 1'b1;
      end else if (hang_clr) begin
        hang <= 1'b0;
      end else begin
        hang <= hang;
      end
    end
  end

endmodule

// File: rtl/axil_iic_master.sv
// One-outstanding AXI4-Lite initiator: command/response port in, axi_iic_0 register accesses out.
module axil_iic_master
  import axil_iic_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,

  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,

  output logic                hang,
  input  logic                hang_clr,

  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  state_e                state_r;
  logic                  entry_r;
  logic                  aw_done_r;
  logic                  w_done_r;
  logic [ADDR_W-1:0]     addr_r;
  logic [DATA_W-1:0]     wdata_r;
  logic [DATA_W/8-1:0]   wstrb_r;
  logic                  aw_hs_s;
  logic                  w_hs_s;
  logic                  run_s;

  assign aw_hs_s = m_axi_awvalid & m_axi_awready;
  assign w_hs_s  = m_axi_wvalid & m_axi_wready;
  assign run_s   = is_wait_state(state_r);

  // Payloads come straight from the command latch, so they cannot move while a valid is up.
  assign m_axi_awaddr = addr_r;
  assign m_axi_araddr = addr_r;
  assign m_axi_wdata  = wdata_r;
  assign m_axi_wstrb  = wstrb_r;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  // Transaction sequencer; every handshake output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      entry_r       <= 1'b0;
      aw_done_r     <= 1'b0;
      w_done_r      <= 1'b0;
      addr_r        <= '0;
      wdata_r       <= '0;
      wstrb_r       <= '0;
      cmd_ready     <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
    end else begin
      entry_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid & cmd_ready) begin
            addr_r    <= cmd_addr;
            wdata_r   <= cmd_wdata;
            wstrb_r   <= cmd_wstrb;
            cmd_ready <= 1'b0;
            entry_r   <= 1'b1;
            if (cmd_write) begin
              aw_done_r     <= 1'b0;
              w_done_r      <= 1'b0;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state_r       <= ST_WR;
            end else begin
              m_axi_arvalid <= 1'b1;
              state_r       <= ST_RD_ADDR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        // AW and W retire independently; leave only once both have been taken.
        ST_WR: begin
          if (aw_hs_s) begin
            m_axi_awvalid <= 1'b0;
            aw_done_r     <= 1'b1;
          end
          if (w_hs_s) begin
            m_axi_wvalid <= 1'b0;
            w_done_r     <= 1'b1;
          end
          if ((aw_done_r | aw_hs_s) & (w_done_r | w_hs_s)) begin
            m_axi_bready <= 1'b1;
            entry_r      <= 1'b1;
            state_r      <= ST_WR_RESP;
          end
        end

        ST_WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_resp     <= m_axi_bresp;
            rsp_rdata    <= '0;
            rsp_valid    <= 1'b1;
            entry_r      <= 1'b1;
            state_r      <= ST_RSP;
          end
        end

        ST_RD_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            entry_r       <= 1'b1;
            state_r       <= ST_RD_DATA;
          end
        end

        ST_RD_DATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            rsp_valid    <= 1'b1;
            entry_r      <= 1'b1;
            state_r      <= ST_RSP;
          end
        end

        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            entry_r   <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end

        default: begin
          state_r       <= ST_IDLE;
          cmd_ready     <= 1'b0;
          m_axi_awvalid <= 1'b0;
          m_axi_wvalid  <= 1'b0;
          m_axi_bready  <= 1'b0;
          m_axi_arvalid <= 1'b0;
          m_axi_rready  <= 1'b0;
          rsp_valid     <= 1'b0;
        end
      endcase
    end
  end

  axil_iic_wdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr      (entry_r),
    .run      (run_s),
    .hang_clr (hang_clr),
    .hang     (hang)
  );

endmodule

// File: tb/tb_axil_iic_master.sv
// Directed plus randomized bench for axil_iic_master against a delay-configurable AXI4-Lite slave.
module tb_axil_iic_master;
  import axil_iic_pkg::*;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [8:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        hang, hang_clr;
  logic [8:0]  m_axi_awaddr, m_axi_araddr;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  int vectors = 0;
  int miscompares = 0;

  // slave knobs, written only by the stimulus
  int         aw_dly = 0, w_dly = 0, ar_dly = 0;
  logic       b_en = 1'b1, r_en = 1'b1;
  logic [1:0] b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;

  axil_iic_master #(.ADDR_W(9), .DATA_W(32), .WDOG_CYCLES(1024)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .hang(hang), .hang_clr(hang_clr),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? d[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  // ---------------- slave model ----------------
  logic [31:0] smem [0:127];
  int          aw_wait, w_wait, ar_wait, b_count;
  logic        aw_got, w_got, r_pend;
  logic [8:0]  aw_addr_q, ar_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        aw_hs, w_hs, ar_hs;
  logic [8:0]  cur_wa, cur_ra;
  logic [31:0] cur_wd;
  logic [3:0]  cur_ws;

  assign m_axi_awready = m_axi_awvalid && (aw_wait >= aw_dly);
  assign m_axi_wready  = m_axi_wvalid  && (w_wait  >= w_dly);
  assign m_axi_arready = m_axi_arvalid && (ar_wait >= ar_dly);
  assign aw_hs  = m_axi_awvalid & m_axi_awready;
  assign w_hs   = m_axi_wvalid & m_axi_wready;
  assign ar_hs  = m_axi_arvalid & m_axi_arready;
  assign cur_wa = aw_hs ? m_axi_awaddr : aw_addr_q;
  assign cur_wd = w_hs ? m_axi_wdata : w_data_q;
  assign cur_ws = w_hs ? m_axi_wstrb : w_strb_q;
  assign cur_ra = ar_hs ? m_axi_araddr : ar_addr_q;

  always @(posedge clk) begin
    if (rst) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      m_axi_bvalid <= 1'b0; m_axi_rvalid <= 1'b0;
      m_axi_bresp <= 2'b00; m_axi_rresp <= 2'b00; m_axi_rdata <= 32'd0;
      aw_addr_q <= 9'd0; ar_addr_q <= 9'd0; w_data_q <= 32'd0; w_strb_q <= 4'd0;
      for (int i = 0; i < 128; i++) smem[i] <= 32'd0;
    end else begin
      aw_wait <= (m_axi_awvalid && !m_axi_awready) ? aw_wait + 1 : 0;
      w_wait  <= (m_axi_wvalid && !m_axi_wready) ? w_wait + 1 : 0;
      ar_wait <= (m_axi_arvalid && !m_axi_arready) ? ar_wait + 1 : 0;
      if (aw_hs) begin aw_addr_q <= m_axi_awaddr; aw_got <= 1'b1; end
      if (w_hs) begin w_data_q <= m_axi_wdata; w_strb_q <= m_axi_wstrb; w_got <= 1'b1; end
      if ((aw_hs || aw_got) && (w_hs || w_got) && b_en && !m_axi_bvalid) begin
        smem[cur_wa[8:2]] <= merge(smem[cur_wa[8:2]], cur_wd, cur_ws);
        m_axi_bvalid <= 1'b1;
        m_axi_bresp  <= b_resp_cfg;
        aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (m_axi_bvalid && m_axi_bready) begin m_axi_bvalid <= 1'b0; b_count <= b_count + 1; end
      if (ar_hs) begin ar_addr_q <= m_axi_araddr; r_pend <= 1'b1; end
      if ((ar_hs || r_pend) && r_en && !m_axi_rvalid) begin
        m_axi_rvalid <= 1'b1;
        m_axi_rdata  <= smem[cur_ra[8:2]];
        m_axi_rresp  <= r_resp_cfg;
        r_pend <= 1'b0;
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
    end
  end

  // ---------------- reference model and helpers ----------------
  logic [31:0] ref_mem [0:127];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic w, input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
    logic acc;
    acc = 1'b0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    for (int i = 0; i < 2000 && !acc; i++) begin
      if (cmd_ready === 1'b1) acc = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    if (!acc) chk("cmd_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic wait_rsp(input int limit, output logic [31:0] rd, output logic [1:0] rs);
    logic got;
    got = 1'b0; rd = 32'd0; rs = 2'b00;
    for (int i = 0; i < limit && !got; i++) begin
      if (rsp_valid === 1'b1) begin
        rd = rsp_rdata; rs = rsp_resp; got = 1'b1;
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
      end else begin
        tick();
      end
    end
    if (!got) chk("rsp_timeout", {31'd0, got}, 32'd1);
  endtask

  // full transaction checked against the reference memory
  task automatic do_txn(input logic w, input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                        input string tag);
    logic [31:0] rd, exp_rd;
    logic [1:0]  rs, exp_rs;
    exp_rs = w ? b_resp_cfg : r_resp_cfg;
    if (w) begin
      ref_mem[a[8:2]] = merge(ref_mem[a[8:2]], d, s);
      exp_rd = 32'd0;
    end else begin
      exp_rd = ref_mem[a[8:2]];
    end
    issue(w, a, d, s);
    wait_rsp(200, rd, rs);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_resp"}, {30'd0, rs}, {30'd0, exp_rs});
    chk({tag, "_idle_ready"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd, snap;
    logic [1:0]  rs;
    logic [8:0]  ra;
    logic [8:0]  reg_list [0:4];
    int          b0;
    logic        seen;

    reg_list[0] = REG_CR; reg_list[1] = REG_SR; reg_list[2] = REG_TX_FIFO;
    reg_list[3] = REG_RX_FIFO; reg_list[4] = REG_GPO;
    for (int i = 0; i < 128; i++) ref_mem[i] = 32'd0;
    b_count = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 9'd0; cmd_wdata = 32'd0;
    cmd_wstrb = 4'd0; rsp_ready = 1'b0; hang_clr = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_valids", {26'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid}, 32'd0);
    chk("rst_hang", {31'd0, hang}, 32'd0);
    chk("rst_rsp", {rsp_rdata[29:0], rsp_resp}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // zero-wait write CR <- 1: AW/W at cycle 1, B at 2, response at 3
    issue(1'b1, REG_CR, 32'h0000_0001, 4'hF);
    ref_mem[REG_CR[8:2]] = 32'h0000_0001;
    chk("wr_c1_aw_w_hs", {30'd0, aw_hs, w_hs}, 32'd3);
    chk("wr_c1_awaddr", {23'd0, m_axi_awaddr}, {23'd0, REG_CR});
    chk("wr_c1_prot", {26'd0, m_axi_awprot, m_axi_arprot}, 32'd0);
    tick();
    chk("wr_c2_b_hs", {30'd0, m_axi_bvalid, m_axi_bready}, 32'd3);
    tick();
    chk("wr_c3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wr_c3_rsp", {rsp_rdata[29:0], rsp_resp}, 32'd0);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    chk("wr_idle_ready", {31'd0, cmd_ready}, 32'd1);

    // SR <- 0xC0, then read it back with arready held off 3 cycles
    do_txn(1'b1, REG_SR, 32'h0000_00C0, 4'hF, "wr_sr");
    ar_dly = 3;
    issue(1'b0, REG_SR, 32'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      chk("ar_wait_hold", {22'd0, m_axi_arvalid, m_axi_arready, m_axi_araddr}, {22'd0, 1'b1, 1'b0, REG_SR});
      tick();
    end
    chk("ar_hs", {31'd0, ar_hs}, 32'd1);
    wait_rsp(50, rd, rs);
    chk("rd_sr_data", rd, 32'h0000_00C0);
    ar_dly = 0;

    // W accepted two cycles before AW; exactly one B
    aw_dly = 2; b0 = b_count;
    issue(1'b1, REG_GPO, 32'hA5A5_1234, 4'h5);
    ref_mem[REG_GPO[8:2]] = merge(ref_mem[REG_GPO[8:2]], 32'hA5A5_1234, 4'h5);
    chk("wfirst_c1", {29'd0, w_hs, aw_hs, m_axi_awvalid}, 32'b101);
    tick();
    chk("wfirst_c2", {30'd0, m_axi_wvalid, m_axi_awvalid}, 32'b01);
    tick();
    chk("wfirst_c3_aw_hs", {31'd0, aw_hs}, 32'd1);
    wait_rsp(50, rd, rs);
    tick(); tick(); tick();
    chk("wfirst_one_b", b_count - b0, 32'd1);
    aw_dly = 0;

    // randomized traffic against the reference memory
    for (int n = 0; n < 24; n++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
      b_resp_cfg = 2'($urandom_range(0, 3)); r_resp_cfg = 2'($urandom_range(0, 3));
      ra = (n % 3 == 0) ? reg_list[$urandom_range(0, 4)] : {7'($urandom_range(0, 127)), 2'b00};
      do_txn(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)), "rand");
    end
    aw_dly = 0; w_dly = 0; ar_dly = 0; b_resp_cfg = RESP_OKAY; r_resp_cfg = RESP_OKAY;

    // slave stalls B: watchdog fires, transaction still completes
    b_en = 1'b0;
    issue(1'b1, REG_TX_FIFO, 32'h0000_0055, 4'h1);
    ref_mem[REG_TX_FIFO[8:2]] = merge(ref_mem[REG_TX_FIFO[8:2]], 32'h0000_0055, 4'h1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = REG_RX_FIFO;
    repeat (1000) tick();
    chk("wdog_early", {31'd0, hang}, 32'd0);
    repeat (40) tick();
    chk("wdog_hang", {31'd0, hang}, 32'd1);
    chk("wdog_state", {29'd0, dut.state_r}, {29'd0, ST_WR_RESP});
    chk("wdog_stall", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b0;
    b_resp_cfg = RESP_SLVERR; b_en = 1'b1;
    wait_rsp(20, rd, rs);
    chk("wdog_slverr", {30'd0, rs}, {30'd0, RESP_SLVERR});
    chk("wdog_sticky", {31'd0, hang}, 32'd1);
    hang_clr = 1'b1; tick(); hang_clr = 1'b0;
    chk("wdog_clr", {31'd0, hang}, 32'd0);
    b_resp_cfg = RESP_OKAY;

    // reset during RD_DATA
    r_en = 1'b0;
    issue(1'b0, REG_CR, 32'd0, 4'd0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (m_axi_rready === 1'b1) seen = 1'b1; else tick();
    end
    chk("rd_data_reached", {31'd0, seen}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_valids", {26'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid}, 32'd0);
    chk("mid_rst_state", {29'd0, dut.state_r}, {29'd0, ST_IDLE});
    for (int i = 0; i < 128; i++) ref_mem[i] = 32'd0;
    r_en = 1'b1;
    tick();
    do_txn(1'b1, REG_CR, 32'h0000_0081, 4'hF, "post_rst_wr");
    do_txn(1'b0, REG_CR, 32'd0, 4'd0, "post_rst_rd");

    // hold rsp_ready low 5 cycles while a new command waits
    issue(1'b0, REG_CR, 32'd0, 4'd0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (rsp_valid === 1'b1) seen = 1'b1; else tick();
    end
    chk("hold_rsp_seen", {31'd0, seen}, 32'd1);
    snap = ref_mem[REG_CR[8:2]];
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = REG_GPO; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid_ready", {30'd0, rsp_valid, cmd_ready}, 32'b10);
      chk("hold_rdata", rsp_rdata, snap);
      tick();
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    chk("hold_no_accept", {29'd0, dut.state_r}, {29'd0, ST_IDLE});
    chk("hold_gpo_untouched", smem[REG_GPO[8:2]], ref_mem[REG_GPO[8:2]]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axil_iic_master.md
# axil_iic_master

AXI4-Lite initiator that turns a simple one-at-a-time command/response port into register reads and writes on the `axi_iic_0` slave interface. It sits between the on-chip control logic and the IIC controller, replacing the scan-chain stimulus used during bring-up with a real protocol driver. It has exactly one transaction outstanding at a time. A watchdog flags stalled transactions.

## Interface
Parameters:
- `ADDR_W`, 9: AXI address width; matches the IIC register map.
- `DATA_W`, 32: AXI data width; strobe width is `DATA_W/8`.
- `WDOG_CYCLES`, 1024: cycles waiting on any AXI channel before `hang` sets; legal range 2..65535.

Ports:
- `clk` input 1: single clock for all logic and the AXI interface.
- `rst` input 1: reset, synchronous, active-high.
- `cmd_valid` / `cmd_ready` input/output 1: command handshake.
- `cmd_write` input 1: 1 selects write, 0 selects read.
- `cmd_addr` input ADDR_W: register byte address.
- `cmd_wdata` input DATA_W: write data.
- `cmd_wstrb` input DATA_W/8: write byte strobes.
- `rsp_valid` / `rsp_ready` output/input 1: response handshake.
- `rsp_rdata` output DATA_W: read data; 0 for writes.
- `rsp_resp` output 2: BRESP or RRESP, passed through unchanged.
- `hang` output 1: sticky watchdog flag.
- `hang_clr` input 1: clears `hang`.
- `m_axi_aw*`, `m_axi_w*`, `m_axi_b*`, `m_axi_ar*`, `m_axi_r*`: standard AXI4-Lite initiator signals sized ADDR_W/DATA_W. The block drives `awprot`/`arprot` = 3'b000.

## Operation
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- **IDLE:** `cmd_ready`=1. A handshake on `cmd_valid & cmd_ready` latches all command fields. Next state is WR if `cmd_write`, otherwise RD_ADDR.
- **WR:** `awvalid` and `wvalid` assert together.
  - Each channel drops independently when its own handshake completes; flags `aw_done`/`w_done` track this.
  - Either order is legal, as is both in the same cycle.
  - When both flags are set, go to WR_RESP.
- **WR_RESP:** `bready`=1. On `bvalid`, capture `bresp`, set rdata=0, go to RSP.
- **RD_ADDR:** `arvalid`=1. On `arready`, go to RD_DATA.
- **RD_DATA:** `rready`=1. On `rvalid`, capture `rdata`/`rresp`, go to RSP.
- **RSP:** `rsp_valid`=1 with fields held stable. On `rsp_ready`, go to IDLE.
- Once a valid is asserted, it is never withdrawn before its ready, and its payload is held stable until then.
- **Watchdog:** a counter clears on every state entry and increments in WR, WR_RESP, RD_ADDR and RD_DATA.
  - When the count reaches WDOG_CYCLES-1, `hang` sets and the counter saturates.
  - The FSM keeps waiting; the transaction is never abandoned.
  - `hang_clr` clears `hang`. If `hang_clr` is asserted in the same cycle as a set, set wins.
- `cmd_ready` is 0 in every state except IDLE, so commands presented while busy are stalled, not dropped.

## Timing
- Reset values: state IDLE, `cmd_ready`=0 during reset and 1 from the first cycle after.
- Also cleared by reset: all AXI valids and readies, `rsp_valid`, `rsp_rdata`, `rsp_resp`, `hang`, and the watchdog counter.
- `rst` mid-transaction drops all valids and readies on the next edge and returns to IDLE. Recovering the slave is the system's job (the IIC core is reset alongside).
- All outputs are registered. The AXI valids assert in the cycle after the command handshake.
- Write latency with a zero-wait slave: command accepted at cycle 0, AW and W handshake at cycle 1, B at cycle 2, `rsp_valid` at cycle 3.
- Read latency with a zero-wait slave: command at cycle 0, AR at cycle 1, R at cycle 2, `rsp_valid` at cycle 3.
- Back-to-back throughput is one transaction per 4 cycles: IDLE follows the RSP handshake, and a new command is accepted in that IDLE cycle.

## Structure
- Package `axil_iic_pkg`:
  - state enum
  - `ADDR_W`/`DATA_W` defaults
  - response codes OKAY/EXOKAY/SLVERR/DECERR
  - IIC register offsets: CR 0x100, SR 0x104, TX_FIFO 0x108, RX_FIFO 0x10C, GPO 0x124
- One sub-module, `axil_iic_wdog`: the saturating counter plus sticky `hang` flag. It takes `clr`, `run` and `WDOG_CYCLES`.

## Test plan
- Zero-wait slave, write 0x100 ← 0x0000_0001 with strobe 0xF:
  - AW/W handshake at cycle 1, `rsp_valid` at cycle 3.
  - `rsp_resp`=0, `rsp_rdata`=0.
- Read 0x104 with `rdata`=0x0000_00C0 and `arready` delayed 3 cycles:
  - `arvalid` stays high with a stable address for those 3 cycles.
  - Response returns `rdata`=0xC0.
- Write with `wready` 2 cycles before `awready`:
  - W handshake completes first.
  - AW completes later.
  - Exactly one B is accepted.
- Slave never asserts `bvalid`: `hang` rises after 1024 cycles, the FSM stays in WR_RESP, and `cmd_ready` stays 0. Then:
  - `bvalid` with SLVERR arrives and is reported as `rsp_resp`=2.
  - `hang` stays 1 until `hang_clr`.
- `rst` asserted during RD_DATA: next cycle, all valids and readies are 0 and state is IDLE. A subsequent read completes normally.
- `rsp_ready` held low for 5 cycles: `rsp_valid` and its fields stay stable throughout, and no new command is accepted.
